vend_multi: RTL and testbench
=============================

Name: vend_multi

Overview:
- Parametrised multi-product vending controller; successor to the single-product, fixed-price drink controller.
- Accepts nickel/dime/quarter pulses into a bounded credit register and serves one of NUM_ITEMS products, each with its own price.
- Returns change one nickel per cycle and supports cancel/refund.
- Sits between the coin acceptor front-end and the dispenser/change-hopper drivers.

Parameters:
- NUM_ITEMS, 4: number of selectable products, minimum 2.
- CREDIT_W, 6: credit register width in nickel units (5 c per LSB).
- MAX_CREDIT, 40: credit ceiling in nickels ($2.00); must be < 2**CREDIT_W.
- PRICE_LIST, {8'd10,8'd7,8'd5,8'd3}: packed 8-bit price per item, in nickels; item 0 is the LSB byte. Defaults are item0=3, item1=5, item2=7, item3=10.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- n, input, 1: nickel inserted, one-cycle pulse, value 1.
- d, input, 1: dime inserted, one-cycle pulse, value 2.
- q, input, 1: quarter inserted, one-cycle pulse, value 5.
- sel_valid, input, 1: product selection strobe.
- sel, input, clog2(NUM_ITEMS): selected item index, sampled when sel_valid=1.
- cancel, input, 1: refund request strobe.
- vend, output, 1: one-cycle dispense pulse.
- vend_item, output, clog2(NUM_ITEMS): item being dispensed, valid while vend=1.
- change_nickel, output, 1: one pulse per nickel returned.
- credit, output, CREDIT_W: current credit in nickels.
- coin_reject, output, 1: one-cycle pulse when the coins offered this cycle are refused.
- short_pulse, output, 1: one-cycle pulse when a selection is refused for insufficient credit.
- busy, output, 1: high in VEND and CHANGE states.

Behaviour:
- While reset=0: state=IDLE and every output is 0, including credit, vend_item and all pulses.
- All outputs are registered.
- States:
  - IDLE: credit=0.
  - CREDIT: credit>0.
  - VEND: the cycle in which vend=1.
  - CHANGE: returning change.
- Coin value per cycle is coin_sum = n + 2*d + 5*q. Simultaneous coins are summed.
- Coin acceptance (IDLE or CREDIT only):
  - If credit + coin_sum <= MAX_CREDIT, add coin_sum next cycle.
  - Otherwise the whole coin set is refused: coin_reject=1 next cycle, credit unchanged.
  - Any nonzero coin_sum in VEND or CHANGE is refused with coin_reject=1.
- IDLE goes to CREDIT on any accepted coin.
- Selection (CREDIT only; ignored in other states):
  - Compare the registered credit, before this cycle's coin, against PRICE_LIST[sel].
  - If credit >= price: next cycle state=VEND, vend=1, vend_item=sel, credit = credit - price.
  - Otherwise short_pulse=1 next cycle, state stays CREDIT, and any same-cycle coin is still accepted.
- Coin and accepted selection in the same cycle: the coin is refused (coin_reject=1); the purchase takes precedence.
- From VEND:
  - Go to CHANGE if the remaining credit > 0, else go to IDLE.
  - vend is deasserted after one cycle.
- CHANGE:
  - Each cycle assert change_nickel=1 and decrement credit by 1.
  - Exit to IDLE on the cycle credit reaches 0.
  - Change for R nickels takes exactly R cycles.
- Cancel:
  - In CREDIT, cancel moves to CHANGE next cycle and refunds the full credit.
  - Cancel wins over a same-cycle sel_valid; a same-cycle coin is refused.
  - Cancel in IDLE, VEND or CHANGE is ignored.
- Invalid index (sel >= NUM_ITEMS when NUM_ITEMS is not a power of 2) is treated as insufficient credit and produces short_pulse.
- Credit never wraps: guaranteed by the MAX_CREDIT check, since MAX_CREDIT < 2**CREDIT_W.
- Reset asserted mid-VEND or mid-CHANGE clears the state immediately. Undispensed change is lost and no further pulses are produced.
- Latency:
  - Coin to credit update: 1 cycle.
  - sel_valid to vend: 1 cycle.
  - First change_nickel appears the cycle after vend.

Test Plan:
1. Reset release, then n, d, d on consecutive cycles gives credit 1, 3, 5. Then sel=1 produces vend=1 with vend_item=1 one cycle later, credit=0, and the state returns to IDLE with no change_nickel.
2. One q (credit=5), then sel=0 (price 3): vend=1, then exactly 2 change_nickel pulses on consecutive cycles, credit reaches 0, busy falls the cycle after the last pulse.
3. Credit=3, then sel=3 (price 10): short_pulse=1, no vend, credit stays 3. Then cancel: 3 change_nickel pulses, return to IDLE.
4. Credit=38, then n=1 and d=1 together (sum 3) gives coin_reject=1 and credit stays 38. Then d alone: credit=40. Then q: coin_reject=1.
5. n, d and q in one cycle: credit=8. During the following CHANGE phase after sel=2 (price 7), a coin is refused with coin_reject=1 and exactly 1 change_nickel is issued.
6. Credit=5, sel=0 with cancel in the same cycle: no vend, 5 change_nickel pulses. Repeat the purchase and drop reset after the first change_nickel: all outputs go to 0 immediately and stay 0 after release.

Source files
------------

// File: rtl/vend_multi.sv
// Multi-product vending controller: bounded nickel-unit credit, per-item prices,
// one-nickel-per-cycle change return and cancel/refund. All outputs registered.
module vend_multi #(
  parameter int                     NUM_ITEMS  = 4,
  parameter int                     CREDIT_W   = 6,
  parameter int                     MAX_CREDIT = 40,
  parameter logic [8*NUM_ITEMS-1:0] PRICE_LIST = {8'd10, 8'd7, 8'd5, 8'd3},
  localparam int                    SEL_W      = $clog2(NUM_ITEMS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                n,
  input  logic                d,
  input  logic                q,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_item,
  output logic                change_nickel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                short_pulse,
  output logic                busy
);

  // Arithmetic width wide enough for credit, an 8-bit price and a carry.
  localparam int AW = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_q, vend_d;
  logic [SEL_W-1:0]    vend_item_q, vend_item_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                short_q, short_d;
  logic                busy_q, busy_d;

  logic [3:0] coin_sum;
  logic [7:0] price;
  logic       sel_ok;
  logic       can_buy;
  logic       coin_fits;
  logic       coin_any;

  always_comb begin
    coin_sum = {3'b000, n} + {2'b00, d, 1'b0} + (q ? 4'd5 : 4'd0);
    coin_any = (coin_sum != 4'd0);

    // Out-of-range indices leave sel_ok low so they read as unaffordable.
    price  = 8'd0;
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel == SEL_W'(i)) begin
        price  = PRICE_LIST[i*8 +: 8];
        sel_ok = 1'b1;
      end
    end
    can_buy   = sel_ok && (AW'(credit_q) >= AW'(price));
    coin_fits = (AW'(credit_q) + AW'(coin_sum)) <= AW'(MAX_CREDIT);

    state_d     = state_q;
    credit_d    = credit_q;
    vend_d      = 1'b0;
    vend_item_d = '0;
    change_d    = 1'b0;
    reject_d    = 1'b0;
    short_d     = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        if (state_q == S_CREDIT && cancel) begin
          state_d  = S_CHANGE;
          change_d = 1'b1;
          credit_d = credit_q - 1'b1;
          reject_d = coin_any;
        end else if (state_q == S_CREDIT && sel_valid && can_buy) begin
          state_d     = S_VEND;
          vend_d      = 1'b1;
          vend_item_d = sel;
          credit_d    = credit_q - CREDIT_W'(price);
          reject_d    = coin_any;
        end else begin
          short_d = (state_q == S_CREDIT) && sel_valid;
          if (coin_any) begin
            if (coin_fits) begin
              credit_d = credit_q + CREDIT_W'(coin_sum);
              state_d  = S_CREDIT;
            end else begin
              reject_d = 1'b1;
            end
          end
        end
      end
      S_VEND, S_CHANGE: begin
        // First refund nickel goes out the cycle after entering; stay until credit is 0.
        reject_d = coin_any;
        if (credit_q != '0) begin
          state_d  = S_CHANGE;
          change_d = 1'b1;
          credit_d = credit_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      credit_q    <= '0;
      vend_q      <= 1'b0;
      vend_item_q <= '0;
      change_q    <= 1'b0;
      reject_q    <= 1'b0;
      short_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      vend_q      <= vend_d;
      vend_item_q <= vend_item_d;
      change_q    <= change_d;
      reject_q    <= reject_d;
      short_q     <= short_d;
      busy_q      <= busy_d;
    end
  end

  assign vend          = vend_q;
  assign vend_item     = vend_item_q;
  assign change_nickel = change_q;
  assign credit        = credit_q;
  assign coin_reject   = reject_q;
  assign short_pulse   = short_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vend_multi.sv
// Directed plus randomized bench for vend_multi against a cycle-level reference model.
module tb_vend_multi;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       n, d, q, sel_valid, cancel;
  logic [1:0] sel;
  logic       vend, change_nickel, coin_reject, short_pulse, busy;
  logic [1:0] vend_item;
  logic [5:0] credit;

  int total = 0;
  int bad   = 0;

  vend_multi dut (
    .clk(clk), .reset(reset), .n(n), .d(d), .q(q),
    .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .vend(vend), .vend_item(vend_item), .change_nickel(change_nickel),
    .credit(credit), .coin_reject(coin_reject), .short_pulse(short_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = shopping (idle/credit), 1 = dispensing, 2 = paying out.
  int price_tab [NI] = '{3, 5, 7, 10};
  int m_credit, m_phase, m_item;
  bit m_vend, m_chg, m_rej, m_short, m_busy;

  task automatic model_reset();
    m_credit = 0; m_phase = 0; m_item = 0;
    m_vend = 0; m_chg = 0; m_rej = 0; m_short = 0; m_busy = 0;
  endtask

  task automatic model_clock(input bit mn, input bit md, input bit mq,
                             input bit msv, input int ms, input bit mc);
    int sum;
    sum = mn + 2*md + 5*mq;
    m_vend = 0; m_item = 0; m_chg = 0; m_rej = 0; m_short = 0;
    if (m_phase != 0) begin
      m_rej = (sum != 0);
      if (m_credit > 0) begin m_phase = 2; m_credit--; m_chg = 1; end
      else m_phase = 0;
    end else if (m_credit > 0 && mc) begin
      m_rej = (sum != 0); m_phase = 2; m_credit--; m_chg = 1;
    end else if (m_credit > 0 && msv && ms < NI && m_credit >= price_tab[ms]) begin
      m_rej = (sum != 0); m_phase = 1; m_vend = 1; m_item = ms;
      m_credit -= price_tab[ms];
    end else begin
      m_short = (m_credit > 0) && msv;
      if (sum != 0) begin
        if (m_credit + sum <= 40) m_credit += sum;
        else m_rej = 1;
      end
    end
    m_busy = (m_phase != 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".vend"},          vend,          m_vend);
    chk({tag, ".vend_item"},     vend_item,     m_item);
    chk({tag, ".change_nickel"}, change_nickel, m_chg);
    chk({tag, ".credit"},        credit,        m_credit);
    chk({tag, ".coin_reject"},   coin_reject,   m_rej);
    chk({tag, ".short_pulse"},   short_pulse,   m_short);
    chk({tag, ".busy"},          busy,          m_busy);
  endtask

  task automatic step(input string tag, input bit tn, input bit td, input bit tq,
                      input bit tsv, input int ts, input bit tc);
    n = tn; d = td; q = tq; sel_valid = tsv; sel = 2'(ts); cancel = tc;
    @(posedge clk);
    model_clock(tn, td, tq, tsv, ts, tc);
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  // Count change pulses from the current cycle until busy drops, bounded.
  task automatic drain(input string tag, input int exp_pulses);
    int cnt;
    cnt = int'(change_nickel);
    for (int i = 0; i < 64 && busy; i++) begin
      idle(tag);
      cnt += int'(change_nickel);
    end
    chk({tag, ".pulses"}, cnt, exp_pulses);
    chk({tag, ".done"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0;
    n = 0; d = 0; q = 0; sel_valid = 0; sel = 0; cancel = 0;
    model_reset();
    #1 compare_all("reset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // 1: n, d, d then buy item 1 exactly
    step("t1n", 1, 0, 0, 0, 0, 0); chk("t1.c1", credit, 1);
    step("t1d", 0, 1, 0, 0, 0, 0); chk("t1.c3", credit, 3);
    step("t1d", 0, 1, 0, 0, 0, 0); chk("t1.c5", credit, 5);
    step("t1s", 0, 0, 0, 1, 1, 0);
    chk("t1.vend", vend, 1); chk("t1.item", vend_item, 1); chk("t1.c0", credit, 0);
    idle("t1i"); chk("t1.busy", busy, 0); chk("t1.nochg", change_nickel, 0);

    // 2: quarter, buy item 0, two nickels back
    step("t2q", 0, 0, 1, 0, 0, 0); chk("t2.c5", credit, 5);
    step("t2s", 0, 0, 0, 1, 0, 0); chk("t2.vend", vend, 1); chk("t2.c2", credit, 2);
    idle("t2a"); chk("t2.chg1", change_nickel, 1); chk("t2.c1", credit, 1);
    idle("t2b"); chk("t2.chg2", change_nickel, 1); chk("t2.busy_last", busy, 1);
    idle("t2c"); chk("t2.chg_end", change_nickel, 0); chk("t2.busy_end", busy, 0);

    // 3: short credit, then cancel
    step("t3n", 1, 1, 0, 0, 0, 0); chk("t3.c3", credit, 3);
    step("t3s", 0, 0, 0, 1, 3, 0);
    chk("t3.short", short_pulse, 1); chk("t3.novend", vend, 0); chk("t3.c3b", credit, 3);
    step("t3x", 0, 0, 0, 0, 0, 1);
    drain("t3drain", 3);

    // 4: ceiling behaviour
    for (int i = 0; i < 7; i++) step("t4q", 0, 0, 1, 0, 0, 0);
    step("t4d", 0, 1, 0, 0, 0, 0);
    step("t4n", 1, 0, 0, 0, 0, 0); chk("t4.c38", credit, 38);
    step("t4nd", 1, 1, 0, 0, 0, 0); chk("t4.rej1", coin_reject, 1); chk("t4.c38b", credit, 38);
    step("t4d2", 0, 1, 0, 0, 0, 0); chk("t4.c40", credit, 40); chk("t4.acc", coin_reject, 0);
    step("t4q2", 0, 0, 1, 0, 0, 0); chk("t4.rej2", coin_reject, 1); chk("t4.c40b", credit, 40);
    step("t4x", 0, 0, 0, 0, 0, 1);
    drain("t4drain", 40);

    // 5: all coins at once, buy item 2, coin during change refused
    step("t5c", 1, 1, 1, 0, 0, 0); chk("t5.c8", credit, 8);
    step("t5s", 0, 0, 0, 1, 2, 0); chk("t5.vend", vend, 1); chk("t5.c1", credit, 1);
    step("t5q", 0, 0, 1, 0, 0, 0);
    chk("t5.chg", change_nickel, 1); chk("t5.rej", coin_reject, 1); chk("t5.c0", credit, 0);
    idle("t5e"); chk("t5.chg_end", change_nickel, 0); chk("t5.idle", busy, 0);

    // 6: cancel beats select; reset during payout
    step("t6q", 0, 0, 1, 0, 0, 0);
    step("t6x", 0, 0, 0, 1, 0, 1); chk("t6.novend", vend, 0);
    drain("t6drain", 5);
    step("t6q2", 0, 0, 1, 0, 0, 0);
    step("t6s", 0, 0, 0, 1, 0, 0); chk("t6.vend", vend, 1);
    idle("t6a"); chk("t6.chg1", change_nickel, 1);
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("t6rst");
    n = 1; q = 1;
    @(posedge clk); #1;
    compare_all("t6hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) idle("t6post");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step("rnd",
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
